// File: rtl/alu.svh
// Shared ALU op-code constants; ALU_OR is only decoded when ALU_OR_EN is defined.
`ifndef ALU_SVH
`define ALU_SVH

`define ALU_AND 3'b000
`define ALU_ADD 3'b001
`define ALU_SUB 3'b010
`define ALU_SLT 3'b011
`define ALU_SRL 3'b100
`define ALU_SLL 3'b101
`define ALU_SRA 3'b110
`define ALU_OR  3'b111

`endif

// File: rtl/alu.sv
// Registered 32-bit integer ALU with equal/overflow/zero flags and one cycle of latency.
// Build option: define ALU_OR_EN to decode op 3'b111 as OR instead of returning zero.
`include "alu.svh"

module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             equal,
  output logic             overflow,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] z_next;
  logic             overflow_next;

  assign sum   = x + y;
  assign diff  = x - y;
  assign shamt = y[SHW-1:0];

  // NOTE: defaults are assigned first so every path through the case drives
  // every output; otherwise synthesis infers latches for the missing paths.
  always_comb begin
    z_next        = '0;
    overflow_next = 1'b0;
    case (op)
      `ALU_AND: z_next = x & y;
      `ALU_ADD: begin
        z_next        = sum;
        overflow_next = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      `ALU_SUB: begin
        z_next        = diff;
        overflow_next = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      end
      // A signed compare stays correct where the sign of x - y would be wrong.
      `ALU_SLT: z_next = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      `ALU_SRL: z_next = x >> shamt;
      `ALU_SLL: z_next = x << shamt;
      `ALU_SRA: z_next = $signed(x) >>> shamt;
`ifdef ALU_OR_EN
      `ALU_OR:  z_next = x | y;
`endif
      default:  z_next = '0;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z        <= '0;
      equal    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      z        <= z_next;
      equal    <= (x == y);
      overflow <= overflow_next;
      zero     <= (z_next == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: op sweep, overflow, SLT, shifts, async reset.
`ifndef ALU_SVH
`include "alu.svh"
`endif

module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] x;
  logic [31:0] y;
  logic [2:0]  op;
  logic [31:0] z;
  logic        equal;
  logic        overflow;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .op       (op),
    .z        (z),
    .equal    (equal),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] exp_z,
                               input logic exp_eq, input logic exp_ov, input logic exp_zero);
    check({tag, ".z"},        z,               exp_z);
    check({tag, ".equal"},    {31'd0, equal},    {31'd0, exp_eq});
    check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_ov});
    check({tag, ".zero"},     {31'd0, zero},     {31'd0, exp_zero});
  endtask

  // Drives one op and checks it just after the next edge; calls chain on
  // consecutive cycles, so the whole sequence runs back-to-back.
  task automatic step(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_z,
                      input logic exp_eq, input logic exp_ov);
    op = o;
    x  = a;
    y  = b;
    @(posedge clk);
    #1;
    check_outputs(tag, exp_z, exp_eq, exp_ov, exp_z == 32'd0);
  endtask

  initial begin
    logic [31:0] or_a, or_c;
`ifdef ALU_OR_EN
    or_a = 32'h0000_00FF;
    or_c = 32'hFFFF_FFFF;
`else
    or_a = 32'h0000_0000;
    or_c = 32'h0000_0000;
`endif

    rst_n = 1'b0;
    op    = `ALU_AND;
    x     = '0;
    y     = '0;
    @(posedge clk);
    #1;
    check_outputs("reset_hold", 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep: pair A=(FF,FF) B=(0,0) C=(-1,0) D=(0,-1) E=(-1,-1)
    step("and_a", `ALU_AND, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 1, 0);
    step("and_b", `ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    step("and_c", `ALU_AND, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 0, 0);
    step("and_d", `ALU_AND, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    step("and_e", `ALU_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);

    step("add_a", `ALU_ADD, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_01FE, 1, 0);
    step("add_b", `ALU_ADD, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    step("add_c", `ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
    step("add_d", `ALU_ADD, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    step("add_e", `ALU_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0);

    step("sub_a", `ALU_SUB, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000, 1, 0);
    step("sub_b", `ALU_SUB, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    step("sub_c", `ALU_SUB, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
    step("sub_d", `ALU_SUB, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
    step("sub_e", `ALU_SUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

    step("slt_a", `ALU_SLT, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000, 1, 0);
    step("slt_b", `ALU_SLT, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    step("slt_c", `ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0);
    step("slt_d", `ALU_SLT, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    step("slt_e", `ALU_SLT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

    step("srl_a", `ALU_SRL, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000, 1, 0);
    step("srl_b", `ALU_SRL, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    step("srl_c", `ALU_SRL, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
    step("srl_d", `ALU_SRL, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    step("srl_e", `ALU_SRL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0);

    step("sll_a", `ALU_SLL, 32'h0000_00FF, 32'h0000_00FF, 32'h8000_0000, 1, 0);
    step("sll_b", `ALU_SLL, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    step("sll_c", `ALU_SLL, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
    step("sll_d", `ALU_SLL, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    step("sll_e", `ALU_SLL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);

    step("sra_a", `ALU_SRA, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000, 1, 0);
    step("sra_b", `ALU_SRA, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    step("sra_c", `ALU_SRA, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
    step("sra_d", `ALU_SRA, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    step("sra_e", `ALU_SRA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);

    step("op7_a", 3'b111, 32'h0000_00FF, 32'h0000_00FF, or_a, 1, 0);
    step("op7_b", 3'b111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    step("op7_c", 3'b111, 32'hFFFF_FFFF, 32'h0000_0000, or_c, 0, 0);
    step("op7_d", 3'b111, 32'h0000_0000, 32'hFFFF_FFFF, or_c, 0, 0);
    step("op7_e", 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, or_c, 1, 0);

    step("ovf_add_pos", `ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1);
    step("ovf_sub_neg", `ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1);
    step("add_neg_neg", `ALU_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0);
    step("ovf_sub_mix", `ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    step("ovf_then_and", `ALU_AND, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0);

    step("slt_ovf",   `ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0, 0);
    step("slt_ovf_r", `ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
    step("slt_eq",    `ALU_SLT, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0);

    step("srl_amt4", `ALU_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 0, 0);
    step("sra_amt4", `ALU_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0, 0);
    step("sll_amt4", `ALU_SLL, 32'h8000_0000, 32'h0000_0024, 32'h0000_0000, 0, 0);
    step("sll_amt0", `ALU_SLL, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 0, 0);

    // Asynchronous reset mid-stream, between clock edges.
    step("pre_reset", `ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 32'd0, 1'b0, 1'b0, 1'b1);
    op = `ALU_AND;
    x  = 32'hFFFF_FFFF;
    y  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check_outputs("reset_held", 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    op = `ALU_SUB;
    x  = 32'h0000_0010;
    y  = 32'h0000_0003;
    #1;
    check_outputs("release_no_edge", 32'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_outputs("first_after_reset", 32'h0000_000D, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
